// File: rtl/cep_delta_pkg.sv
// cep_delta_pkg: shared constants, state encoding and sample types for the
// cepstral delta calculator (cep_delta_calc and its history register file).
package cep_delta_pkg;

    localparam int DATA_WIDTH  = 16;
    localparam int NUM_CEP     = 13;
    localparam int IDX_WIDTH   = 6;
    localparam int DELTA_WIDTH = DATA_WIDTH + 3;
    localparam int HIST_FRAMES = 4;

    // Narrowest index that addresses NUM_CEP history entries.
    localparam int ADDR_WIDTH  = (NUM_CEP > 1) ? $clog2(NUM_CEP) : 1;

    typedef enum logic [0:0] {
        WARMUP = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef logic signed [DATA_WIDTH-1:0]  cep_t;
    typedef logic signed [DELTA_WIDTH-1:0] delta_t;

endpackage

// File: rtl/cep_delta_hist.sv
// cep_delta_hist: 4-slot x NUM_CEP coefficient history. One write port at
// (wp, idx); three combinational reads of the same index at slots wp-1
// (frame t-1), wp-3 (frame t-3) and wp (frame t-4, the slot about to be
// overwritten). Reads see the old contents during a same-cycle write.
module cep_delta_hist
    import cep_delta_pkg::*;
(
    input  logic                         clk,
    input  logic [1:0]                   wp,
    input  logic [ADDR_WIDTH-1:0]        idx,
    input  logic signed [DATA_WIDTH-1:0] wr_data,
    input  logic                         wr_en,
    output logic signed [DATA_WIDTH-1:0] rd_m1,
    output logic signed [DATA_WIDTH-1:0] rd_m3,
    output logic signed [DATA_WIDTH-1:0] rd_m4
);

    logic signed [DATA_WIDTH-1:0] mem [HIST_FRAMES][NUM_CEP];
    logic [1:0] ptr_m1;
    logic [1:0] ptr_m3;

    // Two-bit pointer arithmetic wraps modulo the four slots.
    assign ptr_m1 = wp - 2'd1;
    assign ptr_m3 = wp + 2'd1;

    // Store the accepted coefficient; history is never reset, warm-up refills it.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wp][idx] <= wr_data;
        end
    end

    assign rd_m1 = mem[ptr_m1][idx];
    assign rd_m3 = mem[ptr_m3][idx];
    assign rd_m4 = mem[wp][idx];

endmodule

// File: rtl/cep_delta_calc.sv
// cep_delta_calc: consumes MFCC cepstral coefficients (NUM_CEP per frame),
// keeps a 4-frame history and emits regression (N=2) delta numerators
//   d_{t-2}(k) = 2*(c_t(k) - c_{t-4}(k)) + (c_{t-1}(k) - c_{t-3}(k))
// one per accepted coefficient once four full frames are stored. The 1/10
// scaling is left to the downstream stage.
// Build option: define CEP_DELTA_SAT_EN to clip delta_data to the signed
// DATA_WIDTH range and expose a sticky sat_flag output.
module cep_delta_calc
    import cep_delta_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic                          cep_valid,
    output logic                          cep_ready,
    input  logic signed [DATA_WIDTH-1:0]  cep_data,
    output logic                          delta_valid,
    input  logic                          delta_ready,
    output logic signed [DELTA_WIDTH-1:0] delta_data,
    output logic [IDX_WIDTH-1:0]          delta_idx,
    output logic                          delta_last,
    output logic [2:0]                    frames_stored
`ifdef CEP_DELTA_SAT_EN
    ,
    output logic                          sat_flag
`endif
);

    localparam logic [IDX_WIDTH-1:0] K_LAST     = IDX_WIDTH'(NUM_CEP - 1);
    localparam logic [2:0]           FRAMES_MAX = 3'(HIST_FRAMES);

    state_t              state;
    logic [IDX_WIDTH-1:0] k_cnt;
    logic [1:0]          wp;
    logic                accept;
    logic                frame_end;
    logic                vld_p1;
    cep_t                rd_m1;
    cep_t                rd_m3;
    cep_t                rd_m4;
    delta_t              delta_p0;
    delta_t              delta_out_p0;

    // Sign extension to the full delta width before any arithmetic.
    function automatic delta_t sext(input cep_t x);
        return {{(DELTA_WIDTH - DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
    endfunction

    // One output register: accept whenever it is empty or being drained.
    assign cep_ready   = ~vld_p1 | delta_ready;
    assign accept      = cep_valid & cep_ready;
    assign frame_end   = accept & (k_cnt == K_LAST);
    assign delta_valid = vld_p1;

    cep_delta_hist u_hist (
        .clk     (clk),
        .wp      (wp),
        .idx     (k_cnt[ADDR_WIDTH-1:0]),
        .wr_data (cep_data),
        .wr_en   (accept & ~clr),
        .rd_m1   (rd_m1),
        .rd_m3   (rd_m3),
        .rd_m4   (rd_m4)
    );

    // ---- stage p0: combinational delta from the incoming coefficient and history
    assign delta_p0 = ((sext(cep_data) - sext(rd_m4)) <<< 1)
                    + (sext(rd_m1) - sext(rd_m3));

`ifdef CEP_DELTA_SAT_EN
    localparam delta_t SAT_MAX = delta_t'((2 ** (DATA_WIDTH - 1)) - 1);
    localparam delta_t SAT_MIN = delta_t'(-(2 ** (DATA_WIDTH - 1)));

    logic clip_p0;

    function automatic delta_t sat_delta(input delta_t d);
        if (d > SAT_MAX) begin
            return SAT_MAX;
        end else if (d < SAT_MIN) begin
            return SAT_MIN;
        end
        return d;
    endfunction

    function automatic logic is_clipped(input delta_t d);
        return (d > SAT_MAX) || (d < SAT_MIN);
    endfunction

    assign delta_out_p0 = sat_delta(delta_p0);
    assign clip_p0      = is_clipped(delta_p0);

    // Sticky indication that at least one emitted delta was clipped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (clr) begin
            sat_flag <= 1'b0;
        end else if (accept && (state == STREAM) && clip_p0) begin
            sat_flag <= 1'b1;
        end
    end
`else
    assign delta_out_p0 = delta_p0;
`endif

    // Frame bookkeeping: coefficient index, write slot, stored-frame count, state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_cnt         <= '0;
            wp            <= 2'd0;
            frames_stored <= 3'd0;
            state         <= WARMUP;
        end else if (clr) begin
            k_cnt         <= '0;
            wp            <= 2'd0;
            frames_stored <= 3'd0;
            state         <= WARMUP;
        end else if (accept) begin
            if (frame_end) begin
                k_cnt <= '0;
                wp    <= wp + 2'd1;
                if (frames_stored != FRAMES_MAX) begin
                    frames_stored <= frames_stored + 3'd1;
                end
                if (frames_stored == FRAMES_MAX - 3'd1) begin
                    state <= STREAM;
                end
            end else begin
                k_cnt <= k_cnt + IDX_WIDTH'(1);
            end
        end
    end

    // ---- stage p1: output register, loaded on every accept in STREAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1     <= 1'b0;
            delta_data <= '0;
            delta_idx  <= '0;
            delta_last <= 1'b0;
        end else if (clr) begin
            vld_p1     <= 1'b0;
            delta_data <= '0;
            delta_idx  <= '0;
            delta_last <= 1'b0;
        end else if (accept && (state == STREAM)) begin
            vld_p1     <= 1'b1;
            delta_data <= delta_out_p0;
            delta_idx  <= k_cnt;
            delta_last <= (k_cnt == K_LAST);
        end else if (delta_ready) begin
            vld_p1     <= 1'b0;
        end
    end

endmodule

// File: doc/cep_delta_calc.md
Name: cep_delta_calc

Overview:
- Consumer end of the cepstral-coefficient stream: accepts MFCC cepstral coefficients one per cycle, NUM_CEP per frame, in coefficient order.
- Keeps a 4-frame history and emits first-order delta (regression N=2) numerators for the frame two frames behind the newest.
- Sits between the cepstrum/lifter stage and the delta-delta / feature-packing stage.
- Valid/ready handshake on both sides; downstream applies the 1/10 scaling.

Parameters:
- DATA_WIDTH, 16, signed cepstral coefficient width.
- NUM_CEP, 13, coefficients per frame (1..63).
- IDX_WIDTH, 6, coefficient index width; must satisfy 2^IDX_WIDTH > NUM_CEP.
- DELTA_WIDTH, DATA_WIDTH+3, signed delta output width; sized so the result is lossless.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous utterance restart; clears history count, pointers and output valid
- cep_valid  in  1  input coefficient valid
- cep_ready  out  1  block accepts the coefficient this cycle
- cep_data  in  DATA_WIDTH  signed coefficient c_t(k)
- delta_valid  out  1  output valid
- delta_ready  in  1  downstream accepts
- delta_data  out  DELTA_WIDTH  signed delta numerator d_{t-2}(k)
- delta_idx  out  IDX_WIDTH  coefficient index k of delta_data
- delta_last  out  1  high with k = NUM_CEP-1
- frames_stored  out  3  number of complete frames in history, saturates at 4

Behaviour:
- Reset (rst_n low, asynchronous) and clr (synchronous) both force the following: delta_valid=0, delta_data=0, delta_idx=0, delta_last=0, frames_stored=0, coefficient counter=0, write slot pointer=0, state=WARMUP.
  - History contents are not cleared.
  - clr takes priority over any handshake in the same cycle, and any pending output is dropped.
- Accept: an input is accepted when cep_valid && cep_ready.
  - cep_ready = ~delta_valid | delta_ready, a single output register with no bubble at full throughput.
  - cep_ready is 1 during WARMUP unless an output is still pending.
- Coefficient counter k: increments on each accept and wraps NUM_CEP-1 -> 0.
  - The frame ends on the accept at k = NUM_CEP-1.
  - On frame end, the slot pointer advances mod 4 and frames_stored increments, saturating at 4.
- History: 4 slots x NUM_CEP coefficients.
  - The incoming c_t(k) is written to slot wp at index k on accept.
  - Slots wp-1, wp-2, wp-3 and wp (old content, mod 4) hold frames t-1, t-2, t-3 and t-4 respectively.
- Computation, on accept in STREAM state: d = 2*(c_t(k) - c_{t-4}(k)) + (c_{t-1}(k) - c_{t-3}(k)).
  - All terms are sign-extended to DELTA_WIDTH before arithmetic, so no overflow is possible.
  - c_{t-4}(k) is read from slot wp before the same-cycle write overwrites it; the read-before-write ordering is required.
- States:
  - WARMUP: frames_stored < 4. Inputs are stored and no output is produced.
  - STREAM: frames_stored == 4. Every accept produces one output.
  - Transition WARMUP -> STREAM on the frame-end accept that makes frames_stored = 4; the first output is produced on the first coefficient of the next frame.
  - Transition to WARMUP occurs only via clr or reset.
- Latency: delta_valid rises on the cycle after the accept, with delta_idx = k and delta_last = (k == NUM_CEP-1).
  - Output holds stable while delta_valid && !delta_ready.
- Simultaneous events:
  - Output handshake and new accept in the same cycle: the register reloads and delta_valid stays 1.
  - Output handshake with no new accept (or WARMUP): delta_valid falls to 0.
- Reset mid-frame: the partial frame is discarded, and the next accepted coefficient is k=0 of frame 0.

Optional Feature:
- Macro: CEP_DELTA_SAT_EN.
- Defined: delta_data is saturated to the signed DATA_WIDTH range and sign-extended to DELTA_WIDTH.
  - Saturation limits are +(2^(DATA_WIDTH-1)-1) and -2^(DATA_WIDTH-1).
  - A sticky output sat_flag (1 bit, cleared by reset/clr) sets on any clipped output.
- Undefined: full-precision output and no sat_flag port.

Decomposition:
- Package cep_delta_pkg holds:
  - Constants NUM_CEP, DATA_WIDTH, IDX_WIDTH, DELTA_WIDTH and HIST_FRAMES=4.
  - State enum {WARMUP, STREAM}.
  - A signed delta type.
- Sub-module cep_delta_hist: 4 x NUM_CEP register file.
  - Inputs: write pointer, index, write data and write enable.
  - Outputs: the three combinational reads at wp-1, wp-3 and wp for the same index.

Test Plan:
- Reset/warm-up: feed 4 frames of NUM_CEP=13 coefficients with delta_ready=1 -> delta_valid stays 0, frames_stored reads 1,2,3,4 after each frame end, and cep_ready stays 1 throughout.
- Linear ramp: c_t(k) = 10*t + k for t=0..5 -> frame 4 outputs d=2*40+20=100 for every k, delta_idx 0..12, and delta_last only at k=12.
- Back-pressure: hold delta_ready=0 for 3 cycles mid-frame 5 -> cep_ready=0, delta_data and delta_idx held stable, no coefficient lost or duplicated after release.
- Extremes: with DATA_WIDTH=16, set c_t=+32767, c_{t-1}=+32767, c_{t-3}=-32768, c_{t-4}=-32768 -> d=196605 exactly.
  - With CEP_DELTA_SAT_EN defined: d=32767 and sat_flag=1.
- clr mid-frame: assert clr at k=6 of frame 6 -> outputs dropped, frames_stored=0, WARMUP re-entered; the next 4 frames produce no output, and the 5th frame's first accept yields delta_idx=0.
- Async reset while delta_valid=1 -> delta_valid=0 immediately, without waiting for a clock edge; all outputs read 0 and the block restarts cleanly.
